imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the instruction and address width.
REQ-002 The block SHALL have parameter DEPTH, default 256, giving the number of instruction words stored.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h200, giving the byte address of word 0 (the fetch reset vector).
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 2, range 0..15, giving the wait states between request acceptance and response.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have ports req_valid (in, 1), req_addr (in, DATA_WIDTH) and req_ready (out, 1): the fetch request channel from the fetch stage.
REQ-008 The block SHALL have ports rsp_valid (out, 1), rsp_inst (out, DATA_WIDTH), rsp_err (out, 1) and rsp_ready (in, 1): the response channel.
REQ-009 The block SHALL have port flush, input, 1 bit: cancels any in-flight fetch.
REQ-010 The block SHALL have ports prog_we (in, 1), prog_addr (in, DATA_WIDTH) and prog_data (in, DATA_WIDTH): the word-write port for program load.

Function
REQ-011 The FSM SHALL have states IDLE, WAIT and RESP, with at most one request outstanding.
REQ-012 req_ready SHALL be 1 only in IDLE with flush=0; a request SHALL be accepted on a rising edge where req_valid&req_ready.
REQ-013 On acceptance, req_addr SHALL be latched; the next state SHALL be RESP if WAIT_CYCLES=0, else WAIT with counter=WAIT_CYCLES.
REQ-014 In WAIT the counter SHALL decrement each cycle; when it reaches 1, the next state SHALL be RESP.
REQ-015 Latency: for a request accepted at edge t, rsp_valid SHALL first be 1 after edge t+WAIT_CYCLES.
REQ-016 rsp_inst and rsp_err SHALL be registered on entry to RESP and SHALL stay stable while rsp_valid=1.
REQ-017 In RESP, rsp_valid SHALL stay 1 until an edge with rsp_ready=1, then the FSM SHALL go to IDLE; back-to-back acceptance SHALL need one IDLE cycle.
REQ-018 Index SHALL be (addr-BASE_ADDR)>>2, computed as unsigned DATA_WIDTH arithmetic.
REQ-019 If addr[1:0]!=0, or addr<BASE_ADDR, or addr>=BASE_ADDR+4*DEPTH, the response SHALL be rsp_err=1 with rsp_inst=32'h00000013 (NOP).
REQ-020 Otherwise the response SHALL be rsp_err=0 with rsp_inst equal to the stored word.
REQ-021 flush=1 on an edge SHALL force IDLE, clear the counter and drop any pending or presented response; flush SHALL take priority over req_valid and rsp_ready on the same edge.
REQ-022 prog_we=1 on an edge SHALL write prog_data to the indexed word when prog_addr is aligned and in range; otherwise the write SHALL be ignored.
REQ-023 Writes SHALL be accepted in any state, and a response already latched SHALL be unaffected.
REQ-024 A read in the same cycle as a write to the same word SHALL return the old data.

Reset
REQ-025 reset=0 SHALL asynchronously force state IDLE, counter 0, rsp_valid=0, rsp_err=0 and rsp_inst=0; req_ready SHALL be 1 after reset deasserts.
REQ-026 Reset SHALL NOT clear the storage array; contents after power-up SHALL be undefined until written.
REQ-027 Reset asserted mid-transaction SHALL discard the transaction, with no response produced after release.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/WAIT/RESP), the NOP constant 32'h00000013 and the reset-vector constant 32'h200.
REQ-029 The storage array SHALL be a single sub-module imem_array (1 sync write port, 1 async read port); the FSM and range check SHALL stay in imem_responder.

Verification
REQ-030 Write 32'h00500093 at 0x200 with WAIT_CYCLES=2, request 0x200 accepted at edge t -> rsp_valid after edge t+2, rsp_inst=32'h00500093, rsp_err=0.
REQ-031 Request 0x202 -> rsp_err=1, rsp_inst=32'h00000013; request 0x1FC or 0x600 (DEPTH=256) -> rsp_err=1, rsp_inst=NOP.
REQ-032 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_inst and rsp_err held constant and req_ready=0 throughout.
REQ-033 flush=1 one cycle after acceptance -> IDLE next cycle, no rsp_valid pulse, next request 0x204 returns word 1.
REQ-034 reset=0 pulsed mid-WAIT -> outputs 0 immediately, no response after release, and previously written words still readable.
REQ-035 WAIT_CYCLES=0 with back-to-back requests 0x200, 0x204 and rsp_ready=1 -> responses 1 cycle after each acceptance, accepted every 2 cycles.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the FSM state encoding, the NOP returned on faults, and the fetch reset vector.
package imem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0200;
    localparam int          CNT_W        = 4;

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; a same-edge read sees the pre-write word.
module imem_array
    import imem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int IDX_W      = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding instruction fetch responder with programmable wait states.
// Range/alignment check and the IDLE/WAIT/RESP handshake live here; storage is in imem_array.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 256,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = DATA_WIDTH'(RESET_VECTOR),
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [DATA_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_inst,
    output logic                  rsp_err,
    input  logic                  rsp_ready,
    input  logic                  flush,
    input  logic                  prog_we,
    input  logic [DATA_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so BASE_ADDR + 4*DEPTH cannot wrap at the top of the address space.
    localparam logic [DATA_WIDTH:0] END_ADDR = {1'b0, BASE_ADDR} + (DATA_WIDTH+1)'(4 * DEPTH);

    function automatic logic addr_ok(input logic [DATA_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE_ADDR) && ({1'b0, a} < END_ADDR);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [DATA_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] rsp_inst_q, rsp_inst_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  load_rsp;
    logic [DATA_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    // With zero wait states the response is loaded on the accept edge, so read straight from req_addr.
    assign rd_addr   = (state_q == IDLE) ? req_addr : addr_q;
    assign req_ready = (state_q == IDLE) && !flush;
    assign rsp_valid = (state_q == RESP);
    assign rsp_inst  = rsp_inst_q;
    assign rsp_err   = rsp_err_q;

    imem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (prog_we && addr_ok(prog_addr)),
        .waddr (word_idx(prog_addr)),
        .wdata (prog_data),
        .raddr (word_idx(rd_addr)),
        .rdata (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rsp_inst_d = rsp_inst_q;
        rsp_err_d  = rsp_err_q;
        load_rsp   = 1'b0;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_d = req_addr;
                        if (WAIT_CYCLES == 0) begin
                            state_d  = RESP;
                            load_rsp = 1'b1;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d  = RESP;
                        cnt_d    = '0;
                        load_rsp = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (load_rsp) begin
            rsp_err_d  = !addr_ok(rd_addr);
            rsp_inst_d = addr_ok(rd_addr) ? rd_data : DATA_WIDTH'(NOP_INST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            rsp_inst_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rsp_inst_q <= rsp_inst_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Randomized bench for imem_responder against a transaction-level reference model.
// A second instance with zero wait states is exercised for back-to-back fetches.
module tb_imem_responder;
    localparam int          W     = 2;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h200;
    localparam logic [31:0] LIMIT = 32'h600;
    localparam logic [31:0] NOP   = 32'h13;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, rsp_ready = 1'b0, flush = 1'b0, prog_we = 1'b0;
    logic [31:0] req_addr = '0, prog_addr = '0, prog_data = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_inst;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_inst0;

    always #5 clk = ~clk;

    imem_responder #(.DATA_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_inst(rsp_inst), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    imem_responder #(.DATA_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready0),
        .rsp_valid(rsp_valid0), .rsp_inst(rsp_inst0), .rsp_err(rsp_err0), .rsp_ready(rsp_ready),
        .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: word store plus one outstanding fetch
    logic [31:0] mem_m [DEPTH];
    bit          m_pend = 0, m_valid = 0, m_err = 0;
    int          m_left = 0;
    logic [31:0] m_inst = '0, m_addr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a < BASE) || (a >= LIMIT);
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 9))
            0:       return BASE + 4 * $urandom_range(0, DEPTH-1) + $urandom_range(1, 3);
            1:       return BASE - 4 * $urandom_range(1, 8);
            2:       return LIMIT + 4 * $urandom_range(0, 8);
            default: return BASE + 4 * $urandom_range(0, DEPTH-1);
        endcase
    endfunction

    task automatic drive(input bit rv, input logic [31:0] ra, input bit rr, input bit fl,
                         input bit we, input logic [31:0] pa, input logic [31:0] pd);
        req_valid = rv; req_addr = ra; rsp_ready = rr; flush = fl;
        prog_we = we; prog_addr = pa; prog_data = pd;
        #1;
        chk("req_ready", {31'b0, req_ready}, {31'b0, !m_pend && !m_valid && !fl});
    endtask

    task automatic tick();
        @(posedge clk);
        if (flush) begin
            m_pend = 0; m_valid = 0;
        end else if (m_valid) begin
            if (rsp_ready) m_valid = 0;
        end else if (m_pend) begin
            m_left--;
            if (m_left == 0) begin
                m_pend  = 0;
                m_valid = 1;
                m_err   = addr_bad(m_addr);
                m_inst  = m_err ? NOP : mem_m[idx(m_addr)];
            end
        end else if (req_valid) begin
            m_addr = req_addr; m_pend = 1; m_left = W;
        end
        if (prog_we && !addr_bad(prog_addr)) mem_m[idx(prog_addr)] = prog_data;
        @(negedge clk);
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("rsp_inst", rsp_inst, m_inst);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
        end
    endtask

    task automatic cyc(input bit rv, input logic [31:0] ra, input bit rr, input bit fl);
        drive(rv, ra, rr, fl, 1'b0, '0, '0);
        tick();
    endtask

    task automatic fetch_drain(input logic [31:0] a);
        cyc(1, a, 1, 0);
        for (int n = 0; n < 10 && (m_pend || m_valid); n++) cyc(0, '0, 1, 0);
        chk("drain_idle", {31'b0, m_pend || m_valid}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_inst", rsp_inst, 32'd0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            drive(0, '0, 0, 0, 1, BASE + 4 * i, (i == 0) ? 32'h0050_0093 : $urandom);
            tick();
        end

        // Basic fetch of word 0, then 5 held cycles with rsp_ready low
        cyc(1, BASE, 0, 0);
        cyc(0, '0, 0, 0);
        chk("first_valid_early", {31'b0, rsp_valid}, 32'd0);
        cyc(0, '0, 0, 0);
        chk("word0_inst", rsp_inst, 32'h0050_0093);
        chk("word0_err", {31'b0, rsp_err}, 32'd0);
        for (int i = 0; i < 5; i++) cyc(0, '0, 0, 0);
        cyc(0, '0, 1, 0);

        // Fault addresses
        fetch_drain(32'h202);
        fetch_drain(32'h1FC);
        fetch_drain(32'h600);
        fetch_drain(32'h5FC);

        // Flush one cycle after acceptance
        cyc(1, BASE, 0, 0);
        cyc(0, '0, 0, 1);
        repeat (3) cyc(0, '0, 0, 0);
        fetch_drain(32'h204);

        // Reset pulse mid-WAIT
        cyc(1, 32'h208, 0, 0);
        cyc(0, '0, 0, 0);
        reset = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_inst", rsp_inst, 32'd0);
        chk("midrst_err", {31'b0, rsp_err}, 32'd0);
        m_pend = 0; m_valid = 0;
        #2 reset = 1'b1;
        repeat (4) cyc(0, '0, 0, 0);
        fetch_drain(32'h208);
        fetch_drain(BASE);

        // Random traffic with concurrent writes and flushes
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 1), rnd_addr(), $urandom_range(0, 1), $urandom_range(0, 11) == 0,
                  $urandom_range(0, 2) == 0, rnd_addr(), $urandom);
            tick();
        end

        // Zero-wait instance: back-to-back accepts every two cycles
        cyc(0, '0, 0, 1);
        drive(1, BASE, 1, 0, 0, '0, '0);
        chk("w0_ready_a", {31'b0, req_ready0}, 32'd1);
        tick();
        chk("w0_valid_a", {31'b0, rsp_valid0}, 32'd1);
        chk("w0_inst_a", rsp_inst0, mem_m[0]);
        chk("w0_err_a", {31'b0, rsp_err0}, 32'd0);
        drive(1, BASE + 4, 1, 0, 0, '0, '0);
        chk("w0_ready_b", {31'b0, req_ready0}, 32'd0);
        tick();
        chk("w0_valid_b", {31'b0, rsp_valid0}, 32'd0);
        drive(1, BASE + 4, 1, 0, 0, '0, '0);
        chk("w0_ready_c", {31'b0, req_ready0}, 32'd1);
        tick();
        chk("w0_valid_c", {31'b0, rsp_valid0}, 32'd1);
        chk("w0_inst_c", rsp_inst0, mem_m[1]);
        drive(0, '0, 1, 0, 0, '0, '0);
        tick();
        chk("w0_valid_d", {31'b0, rsp_valid0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
